// File: rtl/ibex_fetch_pkg.sv
// Shared types and helpers for the multi-request instruction fetch FIFO.
package ibex_fetch_pkg;

  localparam int unsigned FETCH_MAX_REQS = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

  function automatic logic is_compressed(input logic [15:0] halfword);
    return halfword[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_fetch_realign.sv
// Combinational realignment of the two oldest fetch words (or the incoming
// word) into one instruction, with compressed detection and error attribution.
module ibex_fetch_realign
  import ibex_fetch_pkg::*;
(
  input  logic         addr_hi_i,
  input  logic         entry0_valid_i,
  input  fetch_entry_t entry0_i,
  input  logic         entry1_valid_i,
  input  fetch_entry_t entry1_i,
  input  logic         in_valid_i,
  input  fetch_entry_t in_entry_i,
  output logic         valid_o,
  output logic         compressed_o,
  output logic [31:0]  rdata_o,
  output logic         err_o,
  output logic         err_plus2_o
);

  fetch_entry_t first;
  fetch_entry_t second;
  logic         first_valid;
  logic         second_valid;
  logic         second_err;

  // The incoming word stands in for whichever of the two oldest slots is empty.
  assign first        = entry0_valid_i ? entry0_i : in_entry_i;
  assign first_valid  = entry0_valid_i | in_valid_i;
  assign second       = entry1_valid_i ? entry1_i : in_entry_i;
  assign second_valid = entry1_valid_i | (entry0_valid_i & in_valid_i);
  assign second_err   = second_valid & second.err;

  assign compressed_o = addr_hi_i ? is_compressed(first.rdata[31:16])
                                  : is_compressed(first.rdata[15:0]);

  always_comb begin
    valid_o     = first_valid;
    rdata_o     = first.rdata;
    err_o       = first.err;
    err_plus2_o = 1'b0;
    if (addr_hi_i) begin
      rdata_o = {second.rdata[15:0], first.rdata[31:16]};
      if (!compressed_o) begin
        valid_o     = second_valid;
        err_o       = first.err | second_err;
        err_plus2_o = ~first.err & second_err;
      end
    end
  end

endmodule

// File: rtl/ibex_fetch_fifo_multi.sv
// Shift-down fetch FIFO with instruction realignment for NUM_REQS outstanding
// requests. Define IBEX_FETCH_FIFO_OCCUPANCY_EN to add the occ_o count output.
module ibex_fetch_fifo_multi
  import ibex_fetch_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  output logic [NUM_REQS-1:0] busy_o,
  input  logic                in_valid_i,
  input  logic [31:0]         in_addr_i,
  input  logic [31:0]         in_rdata_i,
  input  logic                in_err_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_addr_o,
  output logic [31:0]         out_rdata_o,
  output logic                out_err_o,
  output logic                out_err_plus2_o
`ifdef IBEX_FETCH_FIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(NUM_REQS+2)-1:0] occ_o
`endif
);

  localparam int unsigned DEPTH = NUM_REQS + 1;

  if (NUM_REQS < 1 || NUM_REQS > FETCH_MAX_REQS) begin : g_bad_num_reqs
    $error("NUM_REQS out of range");
  end

  logic [DEPTH-1:0] valid_q, valid_d, shift_valid, free, wr_push, wr_en;
  fetch_entry_t     entry_q     [DEPTH];
  fetch_entry_t     shift_entry [DEPTH];
  fetch_entry_t     wr_data     [DEPTH];
  fetch_entry_t     in_entry;
  logic [31:1]      pc_q, pc_d;
  logic             rv_valid, rv_compressed;
  logic             accept, pop, push_en;
  logic             unused_addr0;

  assign in_entry     = '{rdata: in_rdata_i, err: in_err_i};
  assign unused_addr0 = in_addr_i[0];

  ibex_fetch_realign u_realign (
    .addr_hi_i     (pc_q[1]),
    .entry0_valid_i(valid_q[0]),
    .entry0_i      (entry_q[0]),
    .entry1_valid_i(valid_q[1]),
    .entry1_i      (entry_q[1]),
    .in_valid_i    (in_valid_i),
    .in_entry_i    (in_entry),
    .valid_o       (rv_valid),
    .compressed_o  (rv_compressed),
    .rdata_o       (out_rdata_o),
    .err_o         (out_err_o),
    .err_plus2_o   (out_err_plus2_o)
  );

  assign accept = rv_valid & out_ready_i & ~clear_i;
  assign pop    = accept & (pc_q[1] | ~rv_compressed);
  // A pop with entry 0 empty consumed the forwarded word itself, so it is not stored.
  assign push_en = in_valid_i & ~clear_i & ~(pop & ~valid_q[0]);

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      shift_valid[i] = valid_q[i];
      shift_entry[i] = entry_q[i];
    end
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        shift_valid[i] = valid_q[i+1];
        shift_entry[i] = entry_q[i+1];
      end
      shift_valid[DEPTH-1] = 1'b0;
    end
  end

  always_comb begin
    free    = '0;
    free[0] = ~shift_valid[0];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      free[i] = ~shift_valid[i] & shift_valid[i-1];
    end
  end

  assign wr_push = free & {DEPTH{push_en}};

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_en[i]   = wr_push[i] | (pop & shift_valid[i]);
      wr_data[i] = wr_push[i] ? in_entry : shift_entry[i];
    end
  end

  assign valid_d = clear_i ? '0 : (shift_valid | wr_push);

  always_comb begin
    pc_d = pc_q;
    if (clear_i) begin
      pc_d = in_addr_i[31:1];
    end else if (accept) begin
      pc_d = pc_q + (rv_compressed ? 31'd1 : 31'd2);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        entry_q[i] <= wr_data[i];
      end
    end
  end

`ifdef IBEX_FETCH_FIFO_OCCUPANCY_EN
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  logic [OCC_W-1:0] occ_d, occ_q;

  always_comb begin
    occ_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_d[i]) begin
        occ_d = occ_d + OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_o = occ_q;
`endif

  assign busy_o      = valid_q[DEPTH-1 -: NUM_REQS];
  assign out_valid_o = rv_valid;
  assign out_addr_o  = {pc_q, 1'b0};

  // Requester must never push into a full FIFO unless a pop frees a slot.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_valid_i && !clear_i && !pop && valid_q[DEPTH-1]));

endmodule

// File: tb/tb_ibex_fetch_fifo_multi.sv
// Table-driven, scoreboard-checked bench for ibex_fetch_fifo_multi (NUM_REQS=4).
module tb_ibex_fetch_fifo_multi;

  localparam int unsigned NR = 4;
  localparam logic [31:0] MF = 32'hFFFF_FFFF;
  localparam logic [31:0] MC = 32'h0000_FFFF;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic [NR-1:0] busy_o;
  logic          in_valid_i;
  logic [31:0]   in_addr_i;
  logic [31:0]   in_rdata_i;
  logic          in_err_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   out_addr_o;
  logic [31:0]   out_rdata_o;
  logic          out_err_o;
  logic          out_err_plus2_o;
`ifdef IBEX_FETCH_FIFO_OCCUPANCY_EN
  logic [$clog2(NR+2)-1:0] occ_o;
`endif

  ibex_fetch_fifo_multi #(.NUM_REQS(NR)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .busy_o         (busy_o),
    .in_valid_i     (in_valid_i),
    .in_addr_i      (in_addr_i),
    .in_rdata_i     (in_rdata_i),
    .in_err_i       (in_err_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_addr_o     (out_addr_o),
    .out_rdata_o    (out_rdata_o),
    .out_err_o      (out_err_o),
    .out_err_plus2_o(out_err_plus2_o)
`ifdef IBEX_FETCH_FIFO_OCCUPANCY_EN
    ,
    .occ_o          (occ_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        clr;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] rdata;
    logic        err;
    logic        rdy;
    logic        ev;
    logic [3:0]  eb;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [31:0] em;
    logic        ee;
    logic        ep;
    int          occ;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        err;
    logic        plus2;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t V(input logic clr, input logic [31:0] addr, input logic vld,
                             input logic [31:0] rdata, input logic err, input logic rdy,
                             input logic ev, input logic [3:0] eb, input logic [31:0] ea,
                             input logic [31:0] ed, input logic [31:0] em,
                             input logic ee, input logic ep);
    vec_t v;
    v = '{clr, addr, vld, rdata, err, rdy, ev, eb, ea, ed, em, ee, ep, -1};
    return v;
  endfunction

  function automatic vec_t N(input logic clr, input logic [31:0] addr, input logic vld,
                             input logic [31:0] rdata, input logic err, input logic rdy,
                             input logic ev, input logic [3:0] eb);
    return V(clr, addr, vld, rdata, err, rdy, ev, eb, '0, '0, '0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk_i);
    clear_i     = v.clr;
    in_addr_i   = v.addr;
    in_valid_i  = v.vld;
    in_rdata_i  = v.rdata;
    in_err_i    = v.err;
    out_ready_i = v.rdy;
    if (v.ev && v.rdy && !v.clr) begin
      sb.push_back('{v.ea, v.ed, v.em, v.ee, v.ep});
    end
    #2;
    chk($sformatf("row%0d_valid", idx), {31'd0, out_valid_o}, {31'd0, v.ev});
    chk($sformatf("row%0d_busy", idx), {28'd0, busy_o}, {28'd0, v.eb});
`ifdef IBEX_FETCH_FIFO_OCCUPANCY_EN
    if (v.occ >= 0) chk($sformatf("row%0d_occ", idx), 32'(occ_o), 32'(v.occ));
`endif
    if (out_valid_o && out_ready_i && !clear_i) begin
      if (sb.size() == 0) begin
        chk($sformatf("row%0d_unexpected_accept", idx), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("row%0d_addr", idx), out_addr_o, e.addr);
        chk($sformatf("row%0d_rdata", idx), out_rdata_o & e.mask, e.rdata & e.mask);
        chk($sformatf("row%0d_err", idx), {31'd0, out_err_o}, {31'd0, e.err});
        chk($sformatf("row%0d_plus2", idx), {31'd0, out_err_plus2_o}, {31'd0, e.plus2});
      end
    end
  endtask

  initial begin
    // Aligned words after a restart at an odd address (bit 0 dropped).
    tbl.push_back(N(1, 32'h81, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(V(0, 0, 1, 32'h0013_0013, 0, 1, 1, 4'b0000, 32'h80, 32'h0013_0013, MF, 0, 0));
    tbl.push_back(V(0, 0, 1, 32'h0000_0001, 0, 1, 1, 4'b0000, 32'h84, 32'h0000_0001, MC, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b0000, 32'h86, 32'h0000_0000, MC, 0, 0));
    tbl.push_back(N(0, 0, 0, 0, 0, 1, 0, 4'b0000));
    // Unaligned compressed needs one word only.
    tbl.push_back(N(1, 32'h82, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(N(0, 0, 1, 32'h4501_0000, 0, 0, 1, 4'b0000));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b0000, 32'h82, 32'h0000_4501, MC, 0, 0));
    tbl.push_back(V(0, 0, 1, 32'h0000_0593, 0, 1, 1, 4'b0000, 32'h84, 32'h0000_0593, MF, 0, 0));
    tbl.push_back(N(0, 0, 0, 0, 0, 0, 0, 4'b0000));
    // Unaligned uncompressed waits; error in second word flags plus2.
    tbl.push_back(N(1, 32'h82, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(N(0, 0, 1, 32'h0513_0000, 0, 1, 0, 4'b0000));
    tbl.push_back(V(0, 0, 1, 32'h1234_5678, 1, 1, 1, 4'b0000, 32'h82, 32'h5678_0513, MF, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b0000, 32'h86, 32'h0000_1234, MC, 1, 0));
    // Fill to full, then simultaneous push and pop, then drain.
    tbl.push_back(N(1, 32'h100, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(N(0, 0, 1, 32'h1111_0013, 0, 0, 1, 4'b0000));
    tbl.push_back(N(0, 0, 1, 32'h2222_0013, 0, 0, 1, 4'b0000));
    tbl.push_back(N(0, 0, 1, 32'h3333_0013, 0, 0, 1, 4'b0001));
    tbl.push_back(N(0, 0, 1, 32'h4444_0013, 0, 0, 1, 4'b0011));
    tbl.push_back(N(0, 0, 1, 32'h5555_0013, 0, 0, 1, 4'b0111));
    tbl[tbl.size()-1].occ = 4;
    tbl.push_back(N(0, 0, 0, 0, 0, 0, 1, 4'b1111));
    tbl[tbl.size()-1].occ = 5;
    tbl.push_back(V(0, 0, 1, 32'h6666_0013, 0, 1, 1, 4'b1111, 32'h100, 32'h1111_0013, MF, 0, 0));
    tbl.push_back(N(0, 0, 0, 0, 0, 0, 1, 4'b1111));
    tbl[tbl.size()-1].occ = 5;
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b1111, 32'h104, 32'h2222_0013, MF, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b0111, 32'h108, 32'h3333_0013, MF, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b0011, 32'h10C, 32'h4444_0013, MF, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b0001, 32'h110, 32'h5555_0013, MF, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b0000, 32'h114, 32'h6666_0013, MF, 0, 0));
    tbl.push_back(N(0, 0, 0, 0, 0, 1, 0, 4'b0000));
    // Clear during push and accept.
    tbl.push_back(N(0, 0, 1, 32'hAAAA_0013, 0, 0, 1, 4'b0000));
    tbl.push_back(N(0, 0, 1, 32'hBBBB_0013, 0, 0, 1, 4'b0000));
    tbl.push_back(N(1, 32'h200, 1, 32'hCCCC_0013, 0, 1, 1, 4'b0001));
    tbl.push_back(N(0, 0, 0, 0, 0, 1, 0, 4'b0000));
    tbl[tbl.size()-1].occ = 0;
    tbl.push_back(V(0, 0, 1, 32'hDDDD_0013, 0, 1, 1, 4'b0000, 32'h200, 32'hDDDD_0013, MF, 0, 0));
    // Unaligned uncompressed from two stored words, error in the first word.
    tbl.push_back(N(1, 32'h302, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(N(0, 0, 1, 32'h8417_0000, 1, 0, 0, 4'b0000));
    tbl.push_back(N(0, 0, 1, 32'h9ABC_5678, 0, 0, 1, 4'b0000));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b0001, 32'h302, 32'h5678_8417, MF, 1, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 4'b0000, 32'h306, 32'h0000_9ABC, MC, 0, 0));
    tbl.push_back(N(0, 0, 0, 0, 0, 1, 0, 4'b0000));
    // PC wrap at the top of the address space.
    tbl.push_back(N(1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(V(0, 0, 1, 32'h0001_0000, 0, 1, 1, 4'b0000, 32'hFFFF_FFFE, 32'h0000_0001, MC, 0, 0));
    tbl.push_back(V(0, 0, 1, 32'h0000_0013, 0, 1, 1, 4'b0000, 32'h0, 32'h0000_0013, MF, 0, 0));

    rst_ni = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; in_addr_i = '0;
    in_rdata_i = '0; in_err_i = 1'b0; out_ready_i = 1'b0;
    #2;
    chk("reset_valid", {31'd0, out_valid_o}, 32'd0);
    chk("reset_busy", {28'd0, busy_o}, 32'd0);
    chk("reset_addr", out_addr_o, 32'd0);
    in_valid_i = 1'b1; in_rdata_i = 32'h1234_0013;
    #1;
    chk("reset_forward_valid", {31'd0, out_valid_o}, 32'd1);
    chk("reset_forward_rdata", out_rdata_o, 32'h1234_0013);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Reset in the middle of a stream discards stored words.
    apply(N(0, 0, 1, 32'h7777_0013, 0, 0, 1, 4'b0000), 100);
    apply(N(0, 0, 1, 32'h8888_0013, 0, 0, 1, 4'b0000), 101);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    chk("midreset_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midreset_busy", {28'd0, busy_o}, 32'd0);
    chk("midreset_addr", out_addr_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    apply(N(0, 0, 0, 0, 0, 1, 0, 4'b0000), 102);
    chk("postreset_addr", out_addr_o, 32'd0);
    apply(V(0, 0, 1, 32'h9999_0013, 0, 1, 1, 4'b0000, 32'h0, 32'h9999_0013, MF, 0, 0), 103);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
